// File: rtl/csr_access_unit.sv
// CSR access sequencer between the WB stage and the CSR register file.
// Runs one CSR instruction at a time: read the old value, optionally write, then return the old value for rd.
module csr_access_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_num_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [DATA_W-1:0] req_mask_i,
    input  logic [REG_W-1:0]  req_dest_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    input  logic [63:0]       time_64_i,
    input  logic [DATA_W-1:0] time_tid_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic [REG_W-1:0]  resp_dest_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    localparam logic [2:0] OP_CSRRD   = 3'd0;
    localparam logic [2:0] OP_CSRWR   = 3'd1;
    localparam logic [2:0] OP_CSRXCHG = 3'd2;
    localparam logic [2:0] OP_RDCNTVL = 3'd3;
    localparam logic [2:0] OP_RDCNTVH = 3'd4;
    localparam logic [2:0] OP_RDCNTID = 3'd5;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] read_val;

    always_comb begin
        read_val = '0;
        case (op_q)
            OP_CSRRD, OP_CSRWR, OP_CSRXCHG: read_val = csr_rdata_i;
            OP_RDCNTVL: read_val = time_64_i[DATA_W-1:0];
            OP_RDCNTVH: read_val = time_64_i[63:32];
            OP_RDCNTID: read_val = time_tid_i;
            default:    read_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        num_d   = num_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        dest_d  = dest_q;
        old_d   = old_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_d    = req_op_i;
                    num_d   = req_num_i;
                    wdata_d = req_wdata_i;
                    mask_d  = req_mask_i;
                    dest_d  = req_dest_i;
                    state_d = READ;
                end
            end
            READ: begin
                old_d   = read_val;
                state_d = (op_q == OP_CSRWR || op_q == OP_CSRXCHG) ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush abandons whatever is in flight, whatever the state.
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            num_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            dest_q  <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            num_q   <= num_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            dest_q  <= dest_d;
            old_q   <= old_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign csr_raddr_o  = num_q;
    assign csr_waddr_o  = num_q;
    assign csr_we_o     = (state_q == WRITE) && !flush_i;
    // Exchange keeps the bits of the old value that the mask leaves clear.
    assign csr_wdata_o  = (op_q == OP_CSRXCHG) ? ((wdata_q & mask_q) | (old_q & ~mask_q)) : wdata_q;
    assign resp_valid_o = (state_q == RESP) && !flush_i;
    assign resp_rdata_o = old_q;
    assign resp_dest_o  = dest_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: a small CSR file model, expected writes and responses queued at issue.
module tb_csr_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  dest;
    } resp_t;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } write_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = '0;
    logic [13:0] req_num_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [31:0] req_mask_i = '0;
    logic [4:0]  req_dest_i = '0;
    logic        flush_i = 1'b0;
    logic [13:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [13:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [63:0] time_64_i = 64'h0000_0001_FFFF_FFF0;
    logic [31:0] time_tid_i = 32'h5;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_dest_o;
    logic        busy_o;

    logic [31:0] csrMem [0:255];
    resp_t       respQ[$];
    write_t      writeQ[$];
    int          checkCount = 0;
    int          failCount = 0;

    csr_access_unit dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_num_i   (req_num_i),
        .req_wdata_i (req_wdata_i),
        .req_mask_i  (req_mask_i),
        .req_dest_i  (req_dest_i),
        .flush_i     (flush_i),
        .csr_raddr_o (csr_raddr_o),
        .csr_rdata_i (csr_rdata_i),
        .csr_we_o    (csr_we_o),
        .csr_waddr_o (csr_waddr_o),
        .csr_wdata_o (csr_wdata_o),
        .time_64_i   (time_64_i),
        .time_tid_i  (time_tid_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o),
        .resp_dest_o (resp_dest_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    assign csr_rdata_i = csrMem[csr_raddr_o[7:0]];

    always @(posedge clk_i) begin
        if (csr_we_o) csrMem[csr_waddr_o[7:0]] <= csr_wdata_o;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every write strobe and every response handshake must match a queued expectation.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (csr_we_o) begin
                if (writeQ.size() == 0) begin
                    checkOutput("unexpected_we", 1, 0);
                end else begin
                    write_t w;
                    w = writeQ.pop_front();
                    checkOutput("csr_waddr", csr_waddr_o, w.addr);
                    checkOutput("csr_wdata", csr_wdata_o, w.data);
                end
            end
            if (resp_valid_o && resp_ready_i) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_resp", 1, 0);
                end else begin
                    resp_t r;
                    r = respQ.pop_front();
                    checkOutput("resp_rdata", resp_rdata_o, r.rdata);
                    checkOutput("resp_dest", resp_dest_o, r.dest);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [13:0] num, input logic [31:0] wdata,
                                 input logic [31:0] mask, input logic [4:0] dest, input int holdCycles);
        logic [31:0] expOld;
        logic [31:0] heldData;
        bit          isWrite;
        int          waitCnt;
        int          lat;
        int          weLat;
        isWrite = (op == 3'd1) || (op == 3'd2);
        case (op)
            3'd0, 3'd1, 3'd2: expOld = csrMem[num[7:0]];
            3'd3:    expOld = time_64_i[31:0];
            3'd4:    expOld = time_64_i[63:32];
            3'd5:    expOld = time_tid_i;
            default: expOld = 32'h0;
        endcase
        waitCnt = 0;
        while (!req_ready_o && waitCnt < 20) begin
            @(posedge clk_i); #2;
            waitCnt++;
        end
        if (!req_ready_o) checkOutput("req_ready_timeout", 0, 1);
        respQ.push_back('{rdata: expOld, dest: dest});
        if (op == 3'd1) writeQ.push_back('{addr: num, data: wdata});
        if (op == 3'd2) writeQ.push_back('{addr: num, data: (wdata & mask) | (expOld & ~mask)});
        req_op_i    = op;
        req_num_i   = num;
        req_wdata_i = wdata;
        req_mask_i  = mask;
        req_dest_i  = dest;
        req_valid_i = 1'b1;
        @(posedge clk_i); #2;
        req_valid_i = 1'b0;
        req_op_i    = 3'($urandom);
        req_num_i   = 14'($urandom);
        req_wdata_i = $urandom;
        req_mask_i  = $urandom;
        req_dest_i  = 5'($urandom);
        lat = 1;
        weLat = 0;
        while (!resp_valid_o && lat < 10) begin
            if (csr_we_o) weLat = lat;
            @(posedge clk_i); #2;
            lat++;
        end
        checkOutput("resp_latency", lat, isWrite ? 3 : 2);
        checkOutput("we_latency", weLat, isWrite ? 2 : 0);
        for (int h = 0; h < holdCycles; h++) begin
            heldData = resp_rdata_o;
            @(posedge clk_i); #2;
            checkOutput("hold_valid", resp_valid_o, 1);
            checkOutput("hold_rdata", resp_rdata_o, heldData);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #2;
        resp_ready_i = 1'b0;
        checkOutput("idle_after_resp", req_ready_o, 1);
        checkOutput("not_busy_after_resp", busy_o, 0);
    endtask

    task automatic issueToWrite(input logic [13:0] num, input logic [31:0] wdata);
        req_op_i    = 3'd1;
        req_num_i   = num;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        @(posedge clk_i); #2;
        req_valid_i = 1'b0;
        @(posedge clk_i); #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) csrMem[i] = 32'h0;
        csrMem[8'h30] = 32'h1234_5678;
        csrMem[8'h06] = 32'h1C00_0000;
        csrMem[8'h04] = 32'h0000_1FFF;

        #12;
        checkOutput("rst_req_ready", req_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_csr_we", csr_we_o, 0);
        checkOutput("rst_csr_raddr", csr_raddr_o, 0);
        checkOutput("rst_csr_wdata", csr_wdata_o, 0);
        checkOutput("rst_resp_valid", resp_valid_o, 0);
        checkOutput("rst_resp_rdata", resp_rdata_o, 0);
        checkOutput("rst_resp_dest", resp_dest_o, 0);
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        @(posedge clk_i); #2;

        applyStimulus(3'd0, 14'h30, 32'h0, 32'h0, 5'd3, 0);
        applyStimulus(3'd1, 14'h06, 32'hDEAD_BEEF, 32'h0, 5'd7, 0);
        checkOutput("era_written", csrMem[8'h06], 32'hDEAD_BEEF);
        applyStimulus(3'd2, 14'h04, 32'h0000_0A00, 32'h0000_0F00, 5'd9, 0);
        checkOutput("xchg_written", csrMem[8'h04], 32'h0000_1AFF);
        applyStimulus(3'd4, 14'h0, 32'h0, 32'h0, 5'd10, 0);
        applyStimulus(3'd3, 14'h0, 32'h0, 32'h0, 5'd11, 0);
        applyStimulus(3'd5, 14'h0, 32'h0, 32'h0, 5'd12, 0);
        applyStimulus(3'd6, 14'h30, 32'hFFFF_FFFF, 32'h0, 5'd13, 0);
        applyStimulus(3'd0, 14'h06, 32'h0, 32'h0, 5'd14, 5);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'd2, 14'(8'h40 + k), $urandom, $urandom, 5'(k + 16), 0);
        end

        issueToWrite(14'h0A, 32'hCAFE_F00D);
        flush_i = 1'b1;
        #1;
        checkOutput("flush_we_gated", csr_we_o, 0);
        checkOutput("flush_no_resp", resp_valid_o, 0);
        @(posedge clk_i); #2;
        flush_i = 1'b0;
        checkOutput("flush_to_idle", req_ready_o, 1);
        checkOutput("flush_busy", busy_o, 0);
        checkOutput("flush_resp_valid", resp_valid_o, 0);
        checkOutput("flush_no_write", csrMem[8'h0A], 32'h0);

        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_op_i    = 3'd0;
        @(posedge clk_i); #2;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        checkOutput("flush_blocks_accept", busy_o, 0);

        issueToWrite(14'h08, 32'hAAAA_5555);
        checkOutput("in_write_state", csr_we_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid_we", csr_we_o, 0);
        checkOutput("rst_mid_busy", busy_o, 0);
        checkOutput("rst_mid_ready", req_ready_o, 1);
        checkOutput("rst_mid_resp", resp_valid_o, 0);
        @(posedge clk_i); #2;
        checkOutput("rst_mid_no_write", csrMem[8'h08], 32'h0);
        rst_ni = 1'b1;

        applyStimulus(3'd0, 14'h04, 32'h0, 32'h0, 5'd2, 0);
        repeat (2) @(posedge clk_i);
        #2;
        checkOutput("respQ_drained", respQ.size(), 0);
        checkOutput("writeQ_drained", writeQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
